dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data RAM between NCORES harts.
// Define DMEM_ARB_RESV_EN to add per-hart LR.W/SC.W reservation tracking.
module dmem_arbiter #(
  parameter int NCORES     = 2,
  parameter int DMEM_ADDRW = 12
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [NCORES-1:0]            re_packed_i,
  input  logic [NCORES-1:0]            we_packed_i,
  input  logic [DMEM_ADDRW*NCORES-1:0] addr_packed_i,
  input  logic [32*NCORES-1:0]         wdata_packed_i,
  input  logic [4*NCORES-1:0]          wstrb_packed_i,
  input  logic [NCORES-1:0]            is_lr_packed_i,
  input  logic [NCORES-1:0]            is_sc_packed_i,
  output logic [NCORES-1:0]            stall_packed_o,
  output logic [32*NCORES-1:0]         rdata_packed_o,
  output logic                         mem_en_o,
  output logic [3:0]                   mem_wstrb_o,
  output logic [DMEM_ADDRW-1:0]        mem_addr_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int IDXW = (NCORES > 1) ? $clog2(NCORES) : 1;

  logic [NCORES-1:0]     req;
  logic [DMEM_ADDRW-1:0] addr_a  [NCORES];
  logic [31:0]           wdata_a [NCORES];
  logic [3:0]            wstrb_a [NCORES];

  logic [IDXW-1:0] ptr;
  logic            gnt_valid;
  logic [IDXW-1:0] gnt_idx;
  logic            sc_fail;

  logic            rsp_valid;
  logic [IDXW-1:0] rsp_idx;
  logic            rsp_sc;
  logic            rsp_fail;

  assign req = re_packed_i | we_packed_i;

  for (genvar k = 0; k < NCORES; k++) begin : g_unpack
    assign addr_a[k]  = addr_packed_i[k*DMEM_ADDRW +: DMEM_ADDRW];
    assign wdata_a[k] = wdata_packed_i[k*32 +: 32];
    assign wstrb_a[k] = wstrb_packed_i[k*4 +: 4];
  end

  // First requester found scanning upward from ptr (with wrap) wins the RAM.
  always_comb begin
    logic [IDXW-1:0] cand;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    if (!rst_i) begin
      for (int i = 0; i < NCORES; i++) begin
        cand = IDXW'((int'(ptr) + i) % NCORES);
        if (!gnt_valid && req[cand]) begin
          gnt_valid = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NCORES; k++) begin
      stall_packed_o[k] = req[k] && !(gnt_valid && (gnt_idx == IDXW'(k)));
    end
  end

  always_comb begin
    mem_en_o    = gnt_valid;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = 4'b0000;
    if (gnt_valid) begin
      mem_addr_o  = addr_a[gnt_idx];
      mem_wdata_o = wdata_a[gnt_idx];
      if (we_packed_i[gnt_idx] && !sc_fail) begin
        mem_wstrb_o = wstrb_a[gnt_idx];
      end
    end
  end

`ifdef DMEM_ARB_RESV_EN
  logic [NCORES-1:0]     resv_valid;
  logic [DMEM_ADDRW-1:0] resv_addr [NCORES];

  assign sc_fail = gnt_valid && is_sc_packed_i[gnt_idx] &&
                   !(resv_valid[gnt_idx] && (resv_addr[gnt_idx] == addr_a[gnt_idx]));

  // Only one hart is granted per cycle, so an LR and a clearing write never collide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resv_valid <= '0;
    end else if (gnt_valid) begin
      for (int k = 0; k < NCORES; k++) begin
        if ((IDXW'(k) != gnt_idx) && (mem_wstrb_o != 4'b0000) &&
            (resv_addr[k] == addr_a[gnt_idx])) begin
          resv_valid[k] <= 1'b0;
        end
      end
      if (is_sc_packed_i[gnt_idx]) begin
        resv_valid[gnt_idx] <= 1'b0;
      end else if (is_lr_packed_i[gnt_idx]) begin
        resv_valid[gnt_idx] <= 1'b1;
        resv_addr[gnt_idx]  <= addr_a[gnt_idx];
      end
    end
  end
`else
  logic unused_lr;
  assign unused_lr = ^is_lr_packed_i;
  assign sc_fail   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_idx   <= '0;
      rsp_sc    <= 1'b0;
      rsp_fail  <= 1'b0;
    end else begin
      rsp_valid <= gnt_valid;
      rsp_idx   <= gnt_idx;
      rsp_sc    <= gnt_valid && is_sc_packed_i[gnt_idx];
      rsp_fail  <= sc_fail;
      if (gnt_valid) begin
        ptr <= (gnt_idx == IDXW'(NCORES - 1)) ? '0 : gnt_idx + IDXW'(1);
      end
    end
  end

  // Response gated by reset so an in-flight read is dropped immediately.
  always_comb begin
    rdata_packed_o = '0;
    for (int k = 0; k < NCORES; k++) begin
      if (rsp_valid && !rst_i && (rsp_idx == IDXW'(k))) begin
        rdata_packed_o[k*32 +: 32] = rsp_sc ? {31'b0, rsp_fail} : mem_rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: RAM model, behavioural reference and directed scenarios.
// Expectations follow DMEM_ARB_RESV_EN when it is defined for the build.
module tb_dmem_arbiter;

  localparam int N  = 2;
  localparam int AW = 12;
`ifdef DMEM_ARB_RESV_EN
  localparam bit RESV = 1'b1;
`else
  localparam bit RESV = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    re = '0, we = '0, lr = '0, sc = '0;
  logic [AW*N-1:0] addr = '0;
  logic [32*N-1:0] wdata = '0;
  logic [4*N-1:0]  wstrb = '0;
  logic [N-1:0]    stall;
  logic [32*N-1:0] rdata;
  logic            mem_en;
  logic [3:0]      mem_wstrb;
  logic [AW-1:0]   mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata = '0;

  int n_checks = 0;
  int n_errors = 0;
  bit started  = 1'b0;

  dmem_arbiter #(.NCORES(N), .DMEM_ADDRW(AW)) dut (
    .clk_i(clk), .rst_i(rst),
    .re_packed_i(re), .we_packed_i(we), .addr_packed_i(addr),
    .wdata_packed_i(wdata), .wstrb_packed_i(wstrb),
    .is_lr_packed_i(lr), .is_sc_packed_i(sc),
    .stall_packed_o(stall), .rdata_packed_o(rdata),
    .mem_en_o(mem_en), .mem_wstrb_o(mem_wstrb), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM with one-cycle registered read (read-before-write).
  logic [31:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    logic [31:0] t;
    if (mem_en) begin
      t = ram[mem_addr];
      mem_rdata <= t;
      for (int b = 0; b < 4; b++) if (mem_wstrb[b]) t[8*b +: 8] = mem_wdata[8*b +: 8];
      ram[mem_addr] = t;
    end
  end

  // Reference state: pointer, sparse memory image, pending response, reservations.
  int          m_ptr = 0;
  logic [31:0] m_mem [int];
  bit          m_rsp_v = 1'b0;
  int          m_rsp_idx = 0;
  logic [31:0] m_rsp_data = '0;
`ifdef DMEM_ARB_RESV_EN
  bit [N-1:0]    m_rv = '0;
  logic [AW-1:0] m_ra [N];
`endif

  function automatic int expGrant(int p, logic [N-1:0] r);
    int best = -1;
    int bd = N;
    for (int k = 0; k < N; k++) begin
      if (r[k] && ((k - p + N) % N) < bd) begin
        bd = (k - p + N) % N;
        best = k;
      end
    end
    return best;
  endfunction

  function automatic logic [31:0] memRd(int a);
    return m_mem.exists(a) ? m_mem[a] : 32'h0;
  endfunction

  function automatic logic expScFail(int g);
`ifdef DMEM_ARB_RESV_EN
    return sc[g] && !(m_rv[g] && m_ra[g] == addr[g*AW +: AW]);
`else
    return 1'b0 & sc[g];
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  always @(posedge clk) begin
    int g;
    logic [AW-1:0] a;
    logic f;
    logic [3:0] s;
    logic [31:0] old, nw;
    if (rst) begin
      m_ptr = 0;
      m_rsp_v = 1'b0;
`ifdef DMEM_ARB_RESV_EN
      m_rv = '0;
`endif
    end else begin
      g = expGrant(m_ptr, re | we);
      if (g < 0) begin
        m_rsp_v = 1'b0;
      end else begin
        a   = addr[g*AW +: AW];
        f   = expScFail(g);
        old = memRd(int'(a));
        s   = (we[g] && !f) ? wstrb[g*4 +: 4] : 4'h0;
        m_rsp_v = 1'b1;
        m_rsp_idx = g;
        m_rsp_data = sc[g] ? {31'b0, f} : old;
        nw = old;
        for (int b = 0; b < 4; b++) if (s[b]) nw[8*b +: 8] = wdata[g*32 + 8*b +: 8];
        if (s != 4'h0) m_mem[int'(a)] = nw;
`ifdef DMEM_ARB_RESV_EN
        if (s != 4'h0)
          for (int k = 0; k < N; k++) if (k != g && m_rv[k] && m_ra[k] == a) m_rv[k] = 1'b0;
        if (sc[g]) m_rv[g] = 1'b0;
        else if (lr[g]) begin
          m_rv[g] = 1'b1;
          m_ra[g] = a;
        end
`endif
        m_ptr = (g + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    logic [N-1:0] e_stall;
    logic [3:0] e_strb;
    logic [32*N-1:0] e_rdata;
    if (started) begin
      g = rst ? -1 : expGrant(m_ptr, re | we);
      e_stall = re | we;
      e_strb = 4'h0;
      if (g >= 0) begin
        e_stall[g] = 1'b0;
        if (we[g] && !expScFail(g)) e_strb = wstrb[g*4 +: 4];
      end
      e_rdata = '0;
      if (!rst && m_rsp_v) e_rdata[m_rsp_idx*32 +: 32] = m_rsp_data;
      checkOutput("model_stall", 64'(stall), 64'(e_stall));
      checkOutput("model_mem_en", 64'(mem_en), 64'(g >= 0));
      checkOutput("model_mem_wstrb", 64'(mem_wstrb), 64'(e_strb));
      checkOutput("model_rdata", 64'(rdata), 64'(e_rdata));
      if (g >= 0) begin
        checkOutput("model_mem_addr", 64'(mem_addr), 64'(addr[g*AW +: AW]));
        checkOutput("model_mem_wdata", 64'(mem_wdata), 64'(wdata[g*32 +: 32]));
      end
    end
  end

  // Drives one request for hart k, holds it until granted, then drops it.
  task automatic applyStimulus(input int k, input logic r, input logic w, input logic l,
                               input logic s, input logic [AW-1:0] a, input logic [31:0] d,
                               input logic [3:0] st, output logic [3:0] ws);
    bit granted = 1'b0;
    ws = 4'h0;
    re[k] = r; we[k] = w; lr[k] = l; sc[k] = s;
    addr[k*AW +: AW] = a; wdata[k*32 +: 32] = d; wstrb[k*4 +: 4] = st;
    for (int c = 0; c < 8 && !granted; c++) begin
      @(negedge clk);
      if (!stall[k]) begin
        granted = 1'b1;
        ws = mem_wstrb;
      end
      @(posedge clk); #1;
    end
    if (!granted) begin
      n_checks++;
      n_errors++;
      $display("[TB] FAIL grant_timeout: hart %0d got no grant, required one within 8 cycles", k);
    end
    re[k] = 1'b0; we[k] = 1'b0; lr[k] = 1'b0; sc[k] = 1'b0;
  endtask

  initial begin
    logic [3:0] ws;
    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
    @(posedge clk); #1;
    started = 1'b1;

    re = 2'b11;
    addr = {12'h200, 12'h100};
    @(negedge clk);
    checkOutput("rst_stall", 64'(stall), 64'h3);
    checkOutput("rst_mem_en", 64'(mem_en), 64'h0);
    checkOutput("rst_rdata", 64'(rdata), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("rr_stall%0d", i), 64'(stall), (i % 2 == 0) ? 64'h2 : 64'h1);
      @(posedge clk); #1;
    end
    re = 2'b00;

    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'hDEADBEEF, 4'hF, ws);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, ws);
    @(negedge clk);
    checkOutput("rd_h1_data", 64'(rdata[63:32]), 64'hDEADBEEF);
    checkOutput("rd_h0_zero", 64'(rdata[31:0]), 64'h0);
    @(posedge clk); #1;

    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h010, 32'h11223344, 4'b0011, ws);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, ws);
    @(negedge clk);
    checkOutput("partial_wr", 64'(rdata[31:0]), 64'hDEAD3344);
    @(posedge clk); #1;

    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0, ws);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h020, 32'h5, 4'hF, ws);
    checkOutput("sc_ok_wstrb", 64'(ws), 64'hF);
    @(negedge clk);
    checkOutput("sc_ok_rdata", 64'(rdata[31:0]), 64'h0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020, 32'h0, 4'h0, ws);
    @(negedge clk);
    checkOutput("sc_ok_mem", 64'(rdata[63:32]), 64'h5);
    @(posedge clk); #1;

    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h020, 32'h0, 4'h0, ws);
    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h020, 32'h77, 4'hF, ws);
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h020, 32'h99, 4'hF, ws);
    checkOutput("sc_lost_wstrb", 64'(ws), RESV ? 64'h0 : 64'hF);
    @(negedge clk);
    checkOutput("sc_lost_rdata", 64'(rdata[31:0]), RESV ? 64'h1 : 64'h0);
    @(posedge clk); #1;
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h020, 32'h0, 4'h0, ws);
    @(negedge clk);
    checkOutput("sc_lost_mem", 64'(rdata[63:32]), RESV ? 64'h77 : 64'h99);
    @(posedge clk); #1;

    applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b1, 12'h030, 32'h1234, 4'hF, ws);
    checkOutput("sc_nolr_wstrb", 64'(ws), RESV ? 64'h0 : 64'hF);
    @(negedge clk);
    checkOutput("sc_nolr_rdata", 64'(rdata[63:32]), RESV ? 64'h1 : 64'h0);
    @(posedge clk); #1;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h030, 32'h0, 4'h0, ws);
    @(negedge clk);
    checkOutput("sc_nolr_mem", 64'(rdata[31:0]), RESV ? 64'h0 : 64'h1234);
    @(posedge clk); #1;

    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h040, 32'h0, 4'h0, ws);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0, 4'h0, ws);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_rdata", 64'(rdata), 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    re = 2'b11;
    addr = {12'h020, 12'h010};
    @(negedge clk);
    checkOutput("ptr_after_rst", 64'(stall), 64'h2);
    checkOutput("rsp_discarded", 64'(rdata), 64'h0);
    @(posedge clk); #1;
    re[0] = 1'b0;
    @(posedge clk); #1;
    re[1] = 1'b0;
    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 12'h040, 32'hAB, 4'hF, ws);
    @(negedge clk);
    checkOutput("sc_after_rst", 64'(rdata[31:0]), RESV ? 64'h1 : 64'h0);
    @(posedge clk); #1;

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
